// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF neuron array.
package lif_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // Unsigned add clamped to the largest value representable in 'width' bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (33'd1 << width) - 33'd1;
    if (sum > max) begin
      sat_add = max[31:0];
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

endpackage

// File: rtl/lif_neuron_array_if.sv
// Control, stimulus and readback bus of the LIF neuron array.
interface lif_neuron_array_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
) ();
  localparam int CH_W = $clog2(NUM_CH);

  logic              ena;
  logic              step;
  logic              stim_valid;
  logic [CH_W-1:0]   stim_ch;
  logic [WIDTH-1:0]  stim_current;
  logic [WIDTH-1:0]  threshold;
  logic [CH_W-1:0]   vmem_sel;
  logic [WIDTH-1:0]  vmem_out;
  logic [NUM_CH-1:0] spikes;
  logic              busy;
  logic              done;

  modport master (
    output ena, step, stim_valid, stim_ch, stim_current, threshold, vmem_sel,
    input  vmem_out, spikes, busy, done
  );

  modport slave (
    input  ena, step, stim_valid, stim_ch, stim_current, threshold, vmem_sel,
    output vmem_out, spikes, busy, done
  );
endinterface

// File: rtl/lif_neuron_update.sv
// Combinational leak/integrate/fire step for one neuron, shared by all channels.
module lif_neuron_update
  import lif_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 2,
  parameter int REFRACT    = 3,
  parameter int REF_W      = 2
) (
  input  logic [WIDTH-1:0] v_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [REF_W-1:0] ref_i,
  input  logic [WIDTH-1:0] threshold_i,
  output logic [WIDTH-1:0] v_o,
  output logic [REF_W-1:0] ref_o,
  output logic             spike_o
);

  logic [WIDTH-1:0] leaked_s;
  logic [WIDTH-1:0] sum_s;

  // The leaked value never underflows, so only the integrate add needs clamping.
  assign leaked_s = v_i - (v_i >> LEAK_SHIFT);
  assign sum_s    = WIDTH'(sat_add(32'(leaked_s), 32'(acc_i), WIDTH));

  always_comb begin
    v_o     = '0;
    ref_o   = '0;
    spike_o = 1'b0;
    if (ref_i != '0) begin
      ref_o = ref_i - REF_W'(1);
    end else if (sum_s >= threshold_i) begin
      spike_o = 1'b1;
      ref_o   = REF_W'(REFRACT);
    end else begin
      v_o = sum_s;
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// NUM_CH leaky integrate-and-fire neurons swept one per clock through a shared update datapath.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 2,
  parameter int REFRACT    = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  lif_neuron_array_if.slave bus
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int REF_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  vmem_q, vmem_d;
  logic [NUM_CH-1:0] spikes_q, spikes_d;
  logic [WIDTH-1:0]  v_q   [NUM_CH];
  logic [WIDTH-1:0]  v_d   [NUM_CH];
  logic [WIDTH-1:0]  acc_q [NUM_CH];
  logic [WIDTH-1:0]  acc_d [NUM_CH];
  logic [REF_W-1:0]  ref_q [NUM_CH];
  logic [REF_W-1:0]  ref_d [NUM_CH];

  logic [WIDTH-1:0]  upd_v_s;
  logic [REF_W-1:0]  upd_ref_s;
  logic              upd_spike_s;
  logic              updating_s;

  assign updating_s = (state_q == SWEEP);

  lif_neuron_update #(
    .WIDTH      (WIDTH),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRACT    (REFRACT),
    .REF_W      (REF_W)
  ) u_update (
    .v_i         (v_q[idx_q]),
    .acc_i       (acc_q[idx_q]),
    .ref_i       (ref_q[idx_q]),
    .threshold_i (bus.threshold),
    .v_o         (upd_v_s),
    .ref_o       (upd_ref_s),
    .spike_o     (upd_spike_s)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    vmem_d   = v_q[bus.vmem_sel];
    spikes_d = spikes_q;
    v_d      = v_q;
    acc_d    = acc_q;
    ref_d    = ref_q;

    case (state_q)
      IDLE: begin
        if (bus.step) begin
          state_d = SWEEP;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SWEEP: begin
        idx_d = idx_q + CH_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = SWEEP;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    if (updating_s) begin
      v_d[idx_q]      = upd_v_s;
      ref_d[idx_q]    = upd_ref_s;
      spikes_d[idx_q] = upd_spike_s;
      acc_d[idx_q]    = '0;
    end else begin
      spikes_d = spikes_q;
    end

    // Adding onto acc_d (already cleared for the neuron being updated) makes a
    // colliding stimulus land whole in the next step.
    if (bus.stim_valid) begin
      acc_d[bus.stim_ch] = WIDTH'(sat_add(32'(acc_d[bus.stim_ch]), 32'(bus.stim_current), WIDTH));
    end else begin
      acc_d = acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      done_q   <= 1'b0;
      vmem_q   <= '0;
      spikes_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        v_q[i]   <= '0;
        acc_q[i] <= '0;
        ref_q[i] <= '0;
      end
    end else if (bus.ena) begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      vmem_q   <= vmem_d;
      spikes_q <= spikes_d;
      v_q      <= v_d;
      acc_q    <= acc_d;
      ref_q    <= ref_d;
    end
  end

  assign bus.vmem_out = vmem_q;
  assign bus.spikes   = spikes_q;
  assign bus.busy     = (state_q == SWEEP);
  assign bus.done     = done_q;

endmodule
